// File: rtl/bcd_cnt_pkg.sv
// Shared constants for the bcd_cnt display counter: active-low 7-segment codes and digit limits.
// BCD_CNT_HEX_EN selects hexadecimal counting (0..F) instead of decimal (0..9).
`timescale 1ns/1ps
package bcd_cnt_pkg;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_MAX_DEC = 4'd9;
  localparam logic [3:0] DIGIT_MAX_HEX = 4'd15;

`ifdef BCD_CNT_HEX_EN
  localparam logic [3:0] DIGIT_MAX = DIGIT_MAX_HEX;
`else
  localparam logic [3:0] DIGIT_MAX = DIGIT_MAX_DEC;
`endif

endpackage

// File: rtl/bcd_cnt_seg7_decode.sv
// Combinational digit to active-low 7-segment decoder.
// BCD_CNT_HEX_EN adds glyphs A..F; otherwise codes 10..15 blank the display.
`timescale 1ns/1ps
module seg7_decode
  import bcd_cnt_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
`ifdef BCD_CNT_HEX_EN
      4'd10: seg = SEG_A;
      4'd11: seg = SEG_B;
      4'd12: seg = SEG_C;
      4'd13: seg = SEG_D;
      4'd14: seg = SEG_E;
      4'd15: seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_cnt.sv
// Free-running single-digit counter: clock divider tick advances a digit shown on a 7-segment display.
// Define BCD_CNT_HEX_EN for hexadecimal counting; port list is unchanged.
`timescale 1ns/1ps
module bcd_cnt
  import bcd_cnt_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] led
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);

  logic [31:0] div_cnt;
  logic        tick;
  logic [3:0]  digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
      tick    <= 1'b0;
    end
  end

  // The digit steps one clock after the tick is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (tick) begin
      digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

  seg7_decode u_dec (
    .digit (digit),
    .seg   (led)
  );

endmodule

// File: tb/tb_bcd_cnt.sv
// Self-checking bench for bcd_cnt: CLK_DIV=4 and CLK_DIV=1 instances against an edge-count reference model.
// Compile with BCD_CNT_HEX_EN to check the hexadecimal build.
`timescale 1ns/1ps
module tb_bcd_cnt;

`ifdef BCD_CNT_HEX_EN
  localparam int BASE = 16;
`else
  localparam int BASE = 10;
`endif

  logic       clk = 1'b0;
  logic       rst4;
  logic       rst1;
  logic [6:0] led4;
  logic [6:0] led1;

  int n_tests = 0;
  int n_fail  = 0;
  int n4 = 0;
  int n1 = 0;

  always #1 clk = ~clk;

  bcd_cnt #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst4), .led(led4));
  bcd_cnt #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .led(led1));

  // Displayed value after n rising edges since reset release.
  function automatic int exp_digit(input int n, input int div);
    if (n == 0) return 0;
    return ((n - 1) / div) % BASE;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic adv4();
    @(posedge clk);
    n4++;
    #0.5;
  endtask

  task automatic release4();
    @(negedge clk);
    rst4 = 1'b0;
    n4 = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if (led4 !== 7'b1000000 || dut4.digit !== 4'd0 || dut4.tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset t=%0t: led=%b digit=%h tick=%b, required led=1000000 digit=0 tick=0",
                 $time, led4, dut4.digit, dut4.tick);
      end
    end
  endtask

  task automatic test_counting(input int edges);
    logic [6:0] exp;
    release4();
    for (int i = 0; i < edges; i++) begin
      adv4();
      exp = seg_of(exp_digit(n4, 4));
      n_tests++;
      if (led4 !== exp) begin
        n_fail++;
        $display("FAIL counting edge %0d: led=%b required %b", n4, led4, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] exp;
    int target;
    target = 4 * 6 + 1 + int'($urandom_range(0, 3)) + 4 * BASE * int'($urandom_range(0, 1));
    rst4 = 1'b1;
    #0.3;
    release4();
    while (n4 < target) begin
      adv4();
      exp = seg_of(exp_digit(n4, 4));
      n_tests++;
      if (led4 !== exp) begin
        n_fail++;
        $display("FAIL midrst_run edge %0d: led=%b required %b", n4, led4, exp);
      end
    end
    n_tests++;
    if (led4 !== 7'b0000010) begin
      n_fail++;
      $display("FAIL midrst_six: led=%b required 0000010", led4);
    end
    #($urandom_range(1, 13) / 10.0);
    rst4 = 1'b1;
    #0.05;
    n_tests++;
    if (led4 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL midrst_async t=%0t: led=%b required 1000000", $time, led4);
    end
    repeat ($urandom_range(1, 4)) @(posedge clk);
    release4();
    for (int i = 0; i < 9; i++) begin
      adv4();
      exp = seg_of(exp_digit(n4, 4));
      n_tests++;
      if (led4 !== exp) begin
        n_fail++;
        $display("FAIL midrst_restart edge %0d: led=%b required %b", n4, led4, exp);
      end
    end
  endtask

  task automatic test_div1();
    logic [6:0] exp;
    @(negedge clk);
    rst1 = 1'b0;
    n1 = 0;
    n_tests++;
    if (led1 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL div1_reset: led=%b required 1000000", led1);
    end
    for (int i = 0; i < 3 * BASE; i++) begin
      @(posedge clk);
      n1++;
      #0.5;
      exp = seg_of(exp_digit(n1, 1));
      n_tests++;
      if (led1 !== exp) begin
        n_fail++;
        $display("FAIL div1 edge %0d: led=%b required %b", n1, led1, exp);
      end
    end
    rst1 = 1'b1;
  endtask

  task automatic test_long();
    logic [6:0] exp;
    int cycles;
    rst4 = 1'b1;
    #0.3;
    release4();
    cycles = 500 + int'($urandom_range(0, 100));
    for (int i = 0; i < cycles; i++) begin
      adv4();
      exp = seg_of(exp_digit(n4, 4));
      n_tests++;
      if ($isunknown(led4) || led4 !== exp) begin
        n_fail++;
        $display("FAIL long edge %0d: led=%b required %b", n4, led4, exp);
      end
      #1;
      n_tests++;
      if ($isunknown(led4)) begin
        n_fail++;
        $display("FAIL long_xz edge %0d: led=%b required no X/Z", n4, led4);
      end
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    test_reset();
    test_counting(4 * BASE + 12);
    test_mid_reset();
    test_div1();
    test_long();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
